// File: rtl/winograd_out_accum.sv
// ---------------------------------------------------------------------------
// winograd_out_accum
//
// Output accumulator that sits behind one Winograd PE. Result tiles arriving
// from the PE are summed over the input-channel dimension in a wide TILE x
// TILE buffer. Once the configured number of channels has been folded in, the
// finished tile is drained to output memory one row per cycle over a
// valid/ready port. Each element is saturated back to DATA_W on the way out.
// While draining, the block refuses new tiles by holding in_ready_o low.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   cfg_num_id_i   input channels per output tile (0 behaves as 1)
//   res_tile_i     signed result tile, indexed [row][col]
//   res_valid_i    tile and tags valid
//   res_size_i     0: full 6x6 output tile, 1: 4x4 output tile
//   res_od_i       output-channel tag
//   res_x_i        tile origin row
//   res_y_i        tile origin column
//   in_ready_o     tile accepted when res_valid_i && in_ready_o
//   wr_valid_o     memory write row valid
//   wr_ready_i     memory accepts row when wr_valid_o && wr_ready_i
//   wr_data_o      saturated row data, element c goes to column wr_col_o + c
//   wr_mask_o      per-element write enable
//   wr_od_o        output channel of the row
//   wr_row_o       absolute row (tile origin row + row index)
//   wr_col_o       absolute column of element 0
//   err_tag_o      sticky flag: a tile with mismatched tags arrived mid-group
// ---------------------------------------------------------------------------
module winograd_out_accum #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24,
   parameter int TILE   = 6
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [4:0]                            cfg_num_id_i,
   input  logic [TILE-1:0][TILE-1:0][DATA_W-1:0] res_tile_i,
   input  logic                                  res_valid_i,
   input  logic                                  res_size_i,
   input  logic [7:0]                            res_od_i,
   input  logic [8:0]                            res_x_i,
   input  logic [8:0]                            res_y_i,
   output logic                                  in_ready_o,
   output logic                                  wr_valid_o,
   input  logic                                  wr_ready_i,
   output logic [TILE-1:0][DATA_W-1:0]           wr_data_o,
   output logic [TILE-1:0]                       wr_mask_o,
   output logic [7:0]                            wr_od_o,
   output logic [8:0]                            wr_row_o,
   output logic [8:0]                            wr_col_o,
   output logic                                  err_tag_o
);

   // Edge of the reduced tile produced by a 3x3 kernel.
   localparam int SMALL_EDGE = 4;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  buf_q [TILE][TILE];
   logic signed [ACC_W-1:0]  buf_d [TILE][TILE];
   logic [4:0]               id_cnt_q, id_cnt_d;
   logic [4:0]               num_id_q, num_id_d;
   logic [7:0]               od_q, od_d;
   logic [8:0]               x_q, x_d;
   logic [8:0]               y_q, y_d;
   logic                     size_q, size_d;
   logic [2:0]               row_q, row_d;
   logic                     err_q, err_d;

   logic                     accept;
   logic                     tags_match;
   logic [4:0]               num_id_eff;
   logic [2:0]               last_row;

   function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] e);
      return {{(ACC_W-DATA_W){e[DATA_W-1]}}, e};
   endfunction

   // Clamp an accumulator value into the signed DATA_W range. The value fits
   // exactly when every bit from the DATA_W sign bit upward agrees.
   function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-DATA_W:0] top;
      top = v[ACC_W-1:DATA_W-1];
      if ((&top) || !(|top)) begin
         return v[DATA_W-1:0];
      end else if (v[ACC_W-1]) begin
         return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b0, {(DATA_W-1){1'b1}}};
      end
   endfunction

   assign in_ready_o = (state_q == ST_ACCUM);
   assign accept     = res_valid_i && in_ready_o;
   assign err_tag_o  = err_q;

   // A channel count of zero is treated as a single-channel group.
   // tags_match compares against the tags latched from the group's first tile.
   always_comb begin
      num_id_eff = (cfg_num_id_i == 5'd0) ? 5'd1 : cfg_num_id_i;
      tags_match = (res_od_i == od_q) && (res_x_i == x_q) &&
                   (res_y_i == y_q) && (res_size_i == size_q);
      last_row   = size_q ? 3'(SMALL_EDGE - 1) : 3'(TILE - 1);
   end

   // Next-state logic. In ACCUM the first tile of a group overwrites the
   // buffer and latches the group tags and channel count; later tiles are
   // added only when their tags agree, otherwise they are dropped and the
   // error flag is raised. In DRAIN the row index advances on each accepted
   // memory write and the block returns to ACCUM after the last row.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      id_cnt_d = id_cnt_q;
      num_id_d = num_id_q;
      od_d     = od_q;
      x_d      = x_q;
      y_d      = y_q;
      size_d   = size_q;
      row_d    = row_q;
      err_d    = err_q;

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               if (id_cnt_q == 5'd0) begin
                  od_d     = res_od_i;
                  x_d      = res_x_i;
                  y_d      = res_y_i;
                  size_d   = res_size_i;
                  num_id_d = num_id_eff;
                  for (int i = 0; i < TILE; i++) begin
                     for (int j = 0; j < TILE; j++) begin
                        buf_d[i][j] = sext(res_tile_i[i][j]);
                     end
                  end
                  if (num_id_eff == 5'd1) begin
                     state_d  = ST_DRAIN;
                     id_cnt_d = 5'd0;
                     row_d    = 3'd0;
                  end else begin
                     id_cnt_d = 5'd1;
                  end
               end else if (tags_match) begin
                  for (int i = 0; i < TILE; i++) begin
                     for (int j = 0; j < TILE; j++) begin
                        buf_d[i][j] = buf_q[i][j] + sext(res_tile_i[i][j]);
                     end
                  end
                  if ((id_cnt_q + 5'd1) == num_id_q) begin
                     state_d  = ST_DRAIN;
                     id_cnt_d = 5'd0;
                     row_d    = 3'd0;
                  end else begin
                     id_cnt_d = id_cnt_q + 5'd1;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            if (wr_ready_i) begin
               if (row_q == last_row) begin
                  state_d = ST_ACCUM;
                  row_d   = 3'd0;
               end else begin
                  row_d = row_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // Write-port outputs are driven only while draining, so every wr_* output
   // reads zero in ACCUM and straight after reset. Columns beyond the 4x4
   // edge are zeroed and masked off for reduced tiles.
   always_comb begin
      wr_valid_o = 1'b0;
      wr_data_o  = '0;
      wr_mask_o  = '0;
      wr_od_o    = '0;
      wr_row_o   = '0;
      wr_col_o   = '0;
      if (state_q == ST_DRAIN) begin
         wr_valid_o = 1'b1;
         wr_od_o    = od_q;
         wr_row_o   = x_q + {6'd0, row_q};
         wr_col_o   = y_q;
         for (int c = 0; c < TILE; c++) begin
            if (!size_q || (c < SMALL_EDGE)) begin
               wr_data_o[c] = saturate(buf_q[row_q][c]);
               wr_mask_o[c] = 1'b1;
            end
         end
      end
   end

   // State registers. Reset clears the buffer and all counters, which also
   // aborts any drain in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_ACCUM;
         id_cnt_q <= '0;
         num_id_q <= '0;
         od_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         size_q   <= 1'b0;
         row_q    <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
               buf_q[i][j] <= '0;
            end
         end
      end else begin
         state_q  <= state_d;
         id_cnt_q <= id_cnt_d;
         num_id_q <= num_id_d;
         od_q     <= od_d;
         x_q      <= x_d;
         y_q      <= y_d;
         size_q   <= size_d;
         row_q    <= row_d;
         err_q    <= err_d;
         for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
               buf_q[i][j] <= buf_d[i][j];
            end
         end
      end
   end

endmodule

// File: tb/tb_winograd_out_accum.sv
// ---------------------------------------------------------------------------
// tb_winograd_out_accum
//
// Self-checking bench for winograd_out_accum. The stimulus process sends
// directed tile groups and pushes the rows it expects into a queue; an
// independent monitor pops and compares on every write handshake and checks
// that stalled rows stay stable.
// ---------------------------------------------------------------------------
module tb_winograd_out_accum;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 24;
   localparam int TILE   = 6;

   logic                                  clk = 1'b0;
   logic                                  reset;
   logic [4:0]                            cfg_num_id_i;
   logic [TILE-1:0][TILE-1:0][DATA_W-1:0] res_tile_i;
   logic                                  res_valid_i;
   logic                                  res_size_i;
   logic [7:0]                            res_od_i;
   logic [8:0]                            res_x_i;
   logic [8:0]                            res_y_i;
   logic                                  in_ready_o;
   logic                                  wr_valid_o;
   logic                                  wr_ready_i;
   logic [TILE-1:0][DATA_W-1:0]           wr_data_o;
   logic [TILE-1:0]                       wr_mask_o;
   logic [7:0]                            wr_od_o;
   logic [8:0]                            wr_row_o;
   logic [8:0]                            wr_col_o;
   logic                                  err_tag_o;

   always #5 clk = ~clk;

   winograd_out_accum #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .TILE  (TILE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_num_id_i(cfg_num_id_i),
      .res_tile_i  (res_tile_i),
      .res_valid_i (res_valid_i),
      .res_size_i  (res_size_i),
      .res_od_i    (res_od_i),
      .res_x_i     (res_x_i),
      .res_y_i     (res_y_i),
      .in_ready_o  (in_ready_o),
      .wr_valid_o  (wr_valid_o),
      .wr_ready_i  (wr_ready_i),
      .wr_data_o   (wr_data_o),
      .wr_mask_o   (wr_mask_o),
      .wr_od_o     (wr_od_o),
      .wr_row_o    (wr_row_o),
      .wr_col_o    (wr_col_o),
      .err_tag_o   (err_tag_o)
   );

   typedef struct {
      logic [TILE-1:0][DATA_W-1:0] data;
      logic [TILE-1:0]             mask;
      logic [7:0]                  od;
      logic [8:0]                  row;
      logic [8:0]                  col;
   } wr_row_t;

   wr_row_t exp_q[$];
   int      tests_run    = 0;
   int      tests_failed = 0;
   longint  model_acc [TILE][TILE];
   int      ready_mode   = 0;
   int      ready_phase  = 0;

   task automatic checkOutput(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkRow(input string name, input wr_row_t act, input wr_row_t exp);
      tests_run++;
      if (act.data !== exp.data || act.mask !== exp.mask || act.od !== exp.od ||
          act.row !== exp.row || act.col !== exp.col) begin
         tests_failed++;
         $display("[TB] FAIL %s: got od=%0d row=%0d col=%0d mask=%b data=%h, expected od=%0d row=%0d col=%0d mask=%b data=%h",
                  name, act.od, act.row, act.col, act.mask, act.data,
                  exp.od, exp.row, exp.col, exp.mask, exp.data);
      end
   endtask

   function automatic logic [DATA_W-1:0] sat16(input longint v);
      if (v > 32767)       return 16'h7fff;
      else if (v < -32768) return 16'h8000;
      else                 return 16'(v);
   endfunction

   task automatic modelClear();
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++)
            model_acc[i][j] = 0;
   endtask

   task automatic modelAdd(input int base, input bit pat);
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++)
            model_acc[i][j] += base + (pat ? 10 * i + j : 0);
   endtask

   // Queue the rows expected from the current model contents.
   task automatic pushGroup(input logic [7:0] od, input logic [8:0] x, input logic [8:0] y,
                            input logic size, input int nrows);
      wr_row_t e;
      for (int r = 0; r < nrows; r++) begin
         e.od  = od;
         e.row = x + 9'(r);
         e.col = y;
         for (int c = 0; c < TILE; c++) begin
            if (size && c >= 4) begin
               e.data[c] = '0;
               e.mask[c] = 1'b0;
            end else begin
               e.data[c] = sat16(model_acc[r][c]);
               e.mask[c] = 1'b1;
            end
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic driveReady();
      if (ready_mode == 0) begin
         wr_ready_i = 1'b1;
      end else if (ready_mode == 1) begin
         wr_ready_i = ((ready_phase % 3) == 0);
         ready_phase++;
      end else begin
         wr_ready_i = 1'b0;
      end
   endtask

   // Present one tile and hold it until accepted; returns the number of
   // cycles it was refused. Called just after a rising edge.
   task automatic applyStimulus(input int base, input bit pat, input logic [7:0] od,
                                input logic [8:0] x, input logic [8:0] y, input logic size,
                                input logic [4:0] n, output int waited);
      bit done;
      done   = 0;
      waited = 0;
      for (int i = 0; i < TILE; i++)
         for (int j = 0; j < TILE; j++)
            res_tile_i[i][j] = 16'(base + (pat ? 10 * i + j : 0));
      res_od_i     = od;
      res_x_i      = x;
      res_y_i      = y;
      res_size_i   = size;
      cfg_num_id_i = n;
      res_valid_i  = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         driveReady();
         @(negedge clk);
         if (in_ready_o) done = 1;
         else waited++;
         @(posedge clk);
         #1;
      end
      res_valid_i = 1'b0;
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL tile_accept_timeout: got no accept, expected accept");
      end
   endtask

   // Count the cycles in_ready_o stays low.
   task automatic waitReady(output int cycles);
      bit done;
      done   = 0;
      cycles = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         driveReady();
         @(negedge clk);
         if (in_ready_o) done = 1;
         else cycles++;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL ready_timeout: got in_ready low, expected high");
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready_o, 1);
      checkOutput({tag, "_wr_valid"}, wr_valid_o, 0);
      checkOutput({tag, "_wr_data"}, (wr_data_o == '0) ? 0 : 1, 0);
      checkOutput({tag, "_wr_mask"}, wr_mask_o, 0);
      checkOutput({tag, "_wr_od"}, wr_od_o, 0);
      checkOutput({tag, "_wr_row"}, wr_row_o, 0);
      checkOutput({tag, "_wr_col"}, wr_col_o, 0);
      checkOutput({tag, "_err_tag"}, err_tag_o, 0);
   endtask

   // Monitor: compares every accepted write row against the queue, and
   // checks a stalled row is presented unchanged on the following cycle.
   bit      stall_prev = 0;
   wr_row_t stall_row;

   always @(negedge clk) begin
      wr_row_t cur;
      cur.data = wr_data_o;
      cur.mask = wr_mask_o;
      cur.od   = wr_od_o;
      cur.row  = wr_row_o;
      cur.col  = wr_col_o;
      if (reset) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            checkOutput("stall_valid", wr_valid_o, 1);
            checkRow("stall_hold", cur, stall_row);
         end
         if (wr_valid_o && wr_ready_i) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_row: got row=%0d od=%0d, expected no write", cur.row, cur.od);
            end else begin
               checkRow("row", cur, exp_q.pop_front());
            end
            stall_prev = 0;
         end else if (wr_valid_o) begin
            stall_prev = 1;
            stall_row  = cur;
         end else begin
            stall_prev = 0;
         end
      end
   end

   initial begin
      int w;
      reset        = 1'b1;
      cfg_num_id_i = '0;
      res_tile_i   = '0;
      res_valid_i  = 1'b0;
      res_size_i   = 1'b0;
      res_od_i     = '0;
      res_x_i      = '0;
      res_y_i      = '0;
      wr_ready_i   = 1'b1;
      #12;
      checkIdleOutputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single channel, full tile of fives.
      modelClear();
      modelAdd(5, 0);
      pushGroup(8'd3, 9'd12, 9'd18, 1'b0, 6);
      applyStimulus(5, 0, 8'd3, 9'd12, 9'd18, 1'b0, 5'd1, w);
      waitReady(w);
      checkOutput("t1_drain_cycles", w, 6);

      // Four channels, reduced 4x4 tile.
      modelClear();
      pushGroup(8'd1, 9'd30, 9'd40, 1'b1, 0);
      for (int t = 0; t < 4; t++) begin
         modelAdd(1000, 0);
         if (t == 3) pushGroup(8'd1, 9'd30, 9'd40, 1'b1, 4);
         applyStimulus(1000, 0, 8'd1, 9'd30, 9'd40, 1'b1, 5'd4, w);
      end
      waitReady(w);
      checkOutput("t2_drain_cycles", w, 4);

      // Channel count of zero behaves as one.
      modelClear();
      modelAdd(-7, 0);
      pushGroup(8'd2, 9'd1, 9'd2, 1'b1, 4);
      applyStimulus(-7, 0, 8'd2, 9'd1, 9'd2, 1'b1, 5'd0, w);
      waitReady(w);
      checkOutput("cfg0_drain_cycles", w, 4);

      // Sixteen channels at both extremes saturate on output.
      modelClear();
      for (int t = 0; t < 16; t++) modelAdd(32767, 0);
      pushGroup(8'd5, 9'd0, 9'd6, 1'b0, 6);
      for (int t = 0; t < 16; t++) applyStimulus(32767, 0, 8'd5, 9'd0, 9'd6, 1'b0, 5'd16, w);
      waitReady(w);
      modelClear();
      for (int t = 0; t < 16; t++) modelAdd(-32768, 0);
      pushGroup(8'd5, 9'd0, 9'd6, 1'b0, 6);
      for (int t = 0; t < 16; t++) applyStimulus(-32768, 0, 8'd5, 9'd0, 9'd6, 1'b0, 5'd16, w);
      waitReady(w);

      // Two channels with position-dependent data, drained under a 1,0,0
      // ready pattern while the next tile waits at the input.
      modelClear();
      modelAdd(100, 1);
      modelAdd(-30, 1);
      pushGroup(8'd7, 9'd100, 9'd200, 1'b0, 6);
      applyStimulus(100, 1, 8'd7, 9'd100, 9'd200, 1'b0, 5'd2, w);
      applyStimulus(-30, 1, 8'd7, 9'd100, 9'd200, 1'b0, 5'd2, w);
      modelClear();
      modelAdd(9, 0);
      pushGroup(8'd8, 9'd7, 9'd9, 1'b1, 4);
      ready_mode  = 1;
      ready_phase = 0;
      applyStimulus(9, 0, 8'd8, 9'd7, 9'd9, 1'b1, 5'd1, w);
      checkOutput("t4_held_cycles", w, 16);
      ready_mode = 0;
      waitReady(w);
      checkOutput("t4b_drain_cycles", w, 4);

      // Three channels with a mismatched tile dropped in between.
      modelClear();
      modelAdd(100, 0);
      modelAdd(200, 0);
      modelAdd(300, 0);
      pushGroup(8'd9, 9'd3, 9'd4, 1'b0, 6);
      applyStimulus(100, 0, 8'd9, 9'd3, 9'd4, 1'b0, 5'd3, w);
      checkOutput("t5_err_before", err_tag_o, 0);
      applyStimulus(50, 0, 8'd10, 9'd3, 9'd4, 1'b0, 5'd3, w);
      checkOutput("t5_err_set", err_tag_o, 1);
      applyStimulus(200, 0, 8'd9, 9'd3, 9'd4, 1'b0, 5'd3, w);
      checkOutput("t5_in_ready_mid", in_ready_o, 1);
      applyStimulus(300, 0, 8'd9, 9'd3, 9'd4, 1'b0, 5'd3, w);
      waitReady(w);
      checkOutput("t5_drain_cycles", w, 6);
      checkOutput("t5_err_sticky", err_tag_o, 1);

      // Reset while row 2 is presented: only rows 0 and 1 may be written.
      modelClear();
      modelAdd(5, 0);
      pushGroup(8'd2, 9'd40, 9'd50, 1'b0, 2);
      applyStimulus(5, 0, 8'd2, 9'd40, 9'd50, 1'b0, 5'd1, w);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      wr_ready_i = 1'b0;
      @(negedge clk);
      checkOutput("t6_row2_presented", wr_row_o, 42);
      #2;
      reset = 1'b1;
      #1;
      checkIdleOutputs("t6_reset");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("t6_after_reset_valid", wr_valid_o, 0);
      modelClear();
      modelAdd(7, 0);
      pushGroup(8'd2, 9'd40, 9'd50, 1'b0, 6);
      applyStimulus(7, 0, 8'd2, 9'd40, 9'd50, 1'b0, 5'd1, w);
      waitReady(w);
      checkOutput("t6_fresh_drain_cycles", w, 6);

      checkOutput("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
